// File: rtl/prog_lut_pkg.sv
// Shared types and constants for the programmable look-up table.
package prog_lut_pkg;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_LOAD = 1'b1
    } lut_state_e;

    localparam int K_MAX = 6;

    // Number of truth-table entries for a k-input LUT.
    function automatic int table_width(input int k);
        return 32'sd1 << k;
    endfunction

endpackage

// File: rtl/lut_cfg_shifter.sv
// Serial configuration shadow register with transfer counter and final-bit detect.
module lut_cfg_shifter
    import prog_lut_pkg::*;
#(
    parameter int K = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_clear,
    input  logic                      i_shift,
    input  logic                      i_bit,
    output logic [table_width(K)-1:0] o_shadow_next,
    output logic                      o_cfg_out,
    output logic                      o_last
);

    localparam int W  = table_width(K);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  r_shadow;
    logic [CW-1:0] r_count;

    assign o_shadow_next = {r_shadow[W-2:0], i_bit};
    assign o_cfg_out     = r_shadow[W-1];
    // A restart in the same cycle suppresses the transfer, so it can never be the last one.
    assign o_last        = i_shift && !i_clear && (r_count == CW'(W - 1));

    // Shadow shift and accepted-bit counting; a restart only rewinds the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_count  <= '0;
        end else if (i_shift) begin
            r_shadow <= o_shadow_next;
            r_count  <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/prog_lut.sv
// K-input LUT whose truth table can be replaced at run time through a serial, chainable port.
module prog_lut
    import prog_lut_pkg::*;
#(
    parameter int                       K       = 4,
    parameter logic [table_width(K)-1:0] INIT    = '0,
    parameter bit                       REG_OUT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] x,
    output logic         y,
    output logic         y_valid,
    input  logic         cfg_start,
    input  logic         cfg_valid,
    input  logic         cfg_bit,
    output logic         cfg_ready,
    output logic         cfg_done,
    output logic         cfg_out
);

    localparam int W = table_width(K);

    if (K < 1 || K > K_MAX) begin : g_bad_k
        $error("prog_lut: K must lie in 1..K_MAX");
    end

    lut_state_e   r_state;
    logic         r_cfg_ready;
    logic         r_cfg_done;
    logic [W-1:0] r_table;
    logic [W-1:0] w_shadow_next;
    logic         w_xfer;
    logic         w_last;

    assign w_xfer = cfg_valid && r_cfg_ready && !cfg_start;

    lut_cfg_shifter #(.K(K)) u_shifter (
        .clk           (clk),
        .rst           (rst),
        .i_clear       (cfg_start),
        .i_shift       (w_xfer),
        .i_bit         (cfg_bit),
        .o_shadow_next (w_shadow_next),
        .o_cfg_out     (cfg_out),
        .o_last        (w_last)
    );

    // RUN/LOAD sequencing, table commit and configuration handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cfg_ready <= 1'b0;
            r_cfg_done  <= 1'b0;
            r_table     <= INIT;
        end else begin
            r_cfg_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (cfg_start) begin
                        r_state     <= ST_LOAD;
                        r_cfg_ready <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_last) begin
                        r_state     <= ST_RUN;
                        r_cfg_ready <= 1'b0;
                        r_cfg_done  <= 1'b1;
                        r_table     <= w_shadow_next;
                    end
                end
                default: begin
                    r_state     <= ST_RUN;
                    r_cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_done  = r_cfg_done;

    if (REG_OUT) begin : g_reg_out
        logic r_y;
        logic r_y_valid;

        // Lookup sampled against the table as it stood before this edge's commit.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_y       <= 1'b0;
                r_y_valid <= 1'b0;
            end else begin
                r_y       <= r_table[x];
                r_y_valid <= 1'b1;
            end
        end

        assign y       = r_y;
        assign y_valid = r_y_valid;
    end else begin : g_comb_out
        assign y       = r_table[x];
        assign y_valid = !rst;
    end

endmodule

// File: tb/tb_prog_lut.sv
// Directed self-checking bench for prog_lut: cycle model for the registered LUT plus a chained pair.
module tb_prog_lut;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] x = 4'd0;
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_bit = 1'b0;
    logic       y, y_valid, cfg_ready, cfg_done, cfg_out;

    logic [3:0] ch_x = 4'd0;
    logic       ch_start0 = 1'b0;
    logic       ch_start1 = 1'b0;
    logic       ch_valid = 1'b0;
    logic       ch_bit = 1'b0;
    logic       c0_y, c0_yv, c0_ready, c0_done, c0_out;
    logic       c1_y, c1_yv, c1_ready, c1_done, c1_out;

    localparam logic [15:0] INIT = 16'h8000;

    int n_chk = 0;
    int n_err = 0;
    int n_done = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    prog_lut #(.K(4), .INIT(INIT), .REG_OUT(1'b1)) dut (
        .clk(clk), .rst(rst), .x(x), .y(y), .y_valid(y_valid),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
        .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_out(cfg_out)
    );

    prog_lut #(.K(4), .INIT(16'h0000), .REG_OUT(1'b0)) c0 (
        .clk(clk), .rst(rst), .x(ch_x), .y(c0_y), .y_valid(c0_yv),
        .cfg_start(ch_start0), .cfg_valid(ch_valid), .cfg_bit(ch_bit),
        .cfg_ready(c0_ready), .cfg_done(c0_done), .cfg_out(c0_out)
    );

    prog_lut #(.K(4), .INIT(16'h0000), .REG_OUT(1'b0)) c1 (
        .clk(clk), .rst(rst), .x(ch_x), .y(c1_y), .y_valid(c1_yv),
        .cfg_start(ch_start1), .cfg_valid(ch_valid), .cfg_bit(c0_out),
        .cfg_ready(c1_ready), .cfg_done(c1_done), .cfg_out(c1_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: table, shadow word, accepted-bit count and load flag.
    logic [15:0] m_table = INIT;
    logic [15:0] m_shadow = 16'h0000;
    int          m_cnt = 0;
    bit          m_load = 1'b0;
    bit          m_done = 1'b0;
    bit          m_y = 1'b0;
    bit          m_yv = 1'b0;

    always @(posedge clk) begin : model
        logic [15:0] ns;
        int          nc;
        ns = m_shadow;
        nc = m_cnt;
        if (rst) begin
            m_load <= 1'b0; m_table <= INIT; m_shadow <= 16'h0000; m_cnt <= 0;
            m_done <= 1'b0; m_y <= 1'b0; m_yv <= 1'b0;
        end else begin
            m_y    <= m_table[x];
            m_yv   <= 1'b1;
            m_done <= 1'b0;
            if (cfg_start) begin
                m_load <= 1'b1;
                m_cnt  <= 0;
            end else if (m_load && cfg_valid) begin
                ns = {ns[14:0], cfg_bit};
                nc = nc + 1;
                m_shadow <= ns;
                m_cnt    <= nc;
                if (nc == 16) begin
                    m_table <= ns;
                    m_load  <= 1'b0;
                    m_done  <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every dut output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("y", y, m_y);
            check("y_valid", y_valid, m_yv);
            check("cfg_ready", cfg_ready, m_load);
            check("cfg_done", cfg_done, m_done);
            check("cfg_out", cfg_out, m_shadow[15]);
            if (cfg_done === 1'b1) n_done++;
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            cfg_valid = 1'b1;
            cfg_bit   = v[15-i];
            x         = 4'(i);
            step();
            if (gap) begin
                cfg_valid = 1'b0;
                step();
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic sweep(input string name, input logic [15:0] exp);
        for (int i = 0; i < 16; i++) begin
            x = 4'(i);
            step();
            check(name, y, exp[i]);
        end
    endtask

    task automatic ch_send(input logic [15:0] v);
        for (int i = 0; i < 16; i++) begin
            ch_valid = 1'b1;
            ch_bit   = v[15-i];
            step();
        end
        ch_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] t0, t1;
        step();
        step();
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_y_valid", y_valid, 1'b0);
        check("rst_cfg_ready", cfg_ready, 1'b0);
        check("rst_y", y, 1'b0);
        step();
        check("y_valid_after_rst", y_valid, 1'b1);

        sweep("sweep_8000", 16'h8000);

        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        check("ready_in_load", cfg_ready, 1'b1);
        send(16'h6996, 16, 1'b0);
        step(); step();
        check("done_count_6996", n_done, 1);
        x = 4'b0111; step(); check("y_x7_6996", y, 1'b1);
        x = 4'b0011; step(); check("y_x3_6996", y, 1'b0);

        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        send(16'h0F0F, 9, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1; step();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        send(16'hFFFE, 16, 1'b0);
        step(); step();
        check("done_count_fffe", n_done, 2);
        sweep("sweep_fffe", 16'hFFFE);

        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        send(16'h1234, 15, 1'b0);
        cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b0; step();
        cfg_start = 1'b0; cfg_valid = 1'b0;
        step(); step();
        check("no_done_on_restart", n_done, 2);
        check("still_loading", cfg_ready, 1'b1);
        send(16'h6996, 16, 1'b1);
        step(); step();
        check("done_count_gap", n_done, 3);
        sweep("sweep_6996_gap", 16'h6996);

        cfg_start = 1'b1; step(); cfg_start = 1'b0;
        send(16'hABCD, 10, 1'b0);
        rst = 1'b1; step(); rst = 1'b0;
        check("abort_y_valid", y_valid, 1'b0);
        check("abort_cfg_ready", cfg_ready, 1'b0);
        step();
        check("abort_y_valid_back", y_valid, 1'b1);
        step();
        check("abort_no_done", n_done, 3);
        sweep("sweep_init_after_abort", INIT);

        ch_start0 = 1'b1; step(); ch_start0 = 1'b0;
        ch_send(16'hA5C3);
        step();
        ch_start0 = 1'b1; ch_start1 = 1'b1; step();
        ch_start0 = 1'b0; ch_start1 = 1'b0;
        ch_send(16'h1E78);
        step();
        for (int i = 0; i < 16; i++) begin
            ch_x = 4'(i);
            #1;
            t0[i] = c0_y;
            t1[i] = c1_y;
        end
        check("chain_first_table", t0, 16'h1E78);
        check("chain_second_table", t1, 16'hA5C3);
        check("chain_y_valid", c0_yv & c1_yv, 1'b1);

        step();
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/prog_lut.md
PROG_LUT -- requirements
Module: prog_lut

Interface
REQ-001 Parameter K, default 4, number of LUT inputs; legal range 1..6.
REQ-002 Parameter INIT, default all zeros, width 2**K, truth table loaded at reset; bit i is the output for x == i.
REQ-003 Parameter REG_OUT, default 1; 1 means registered y, 0 means combinational y.
REQ-004 Clock and reset are decided: one clock; reset synchronous, active-high.
REQ-005 Port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-006 Port rst, input, 1, synchronous active-high reset.
REQ-007 Port x, input, K, lookup address.
REQ-008 Port y, output, 1, table[x].
REQ-009 Port y_valid, output, 1, y is meaningful.
REQ-010 Port cfg_start, input, 1, single-cycle request to begin serial configuration.
REQ-011 Port cfg_valid, input, 1, cfg_bit carries a valid config bit.
REQ-012 Port cfg_bit, input, 1, serial config data, MSB (table bit 2**K-1) first.
REQ-013 Port cfg_ready, output, 1, block accepts config bits.
REQ-014 Port cfg_done, output, 1, one-cycle pulse when a new table is committed.
REQ-015 Port cfg_out, output, 1, shadow-register MSB for daisy-chaining the next LUT.

Function
REQ-016 Two states: RUN and LOAD; reset enters RUN.
REQ-017 RUN to LOAD on cfg_start; bit counter cleared; cfg_ready=1 from the following cycle, for the whole of LOAD only.
REQ-018 Bit transfer occurs only when cfg_valid && cfg_ready; shadow shifts left, cfg_bit enters shadow[0], counter +1.
REQ-019 cfg_valid low in LOAD: no shift, no count; gaps of any length are legal.
REQ-020 The transfer that brings the counter to 2**K copies the updated shadow to the active table.
REQ-021 That same commit edge sets cfg_done=1 for exactly one cycle and returns the state to RUN.
REQ-022 cfg_start in LOAD restarts the load: counter=0, prior partial bits discarded by count; same cycle's transfer ignored.
REQ-023 cfg_start coincident with the final transfer restarts; no commit, no cfg_done.
REQ-024 The active table is unchanged during LOAD; lookups continue with the old table; y_valid stays 1.
REQ-025 REG_OUT=0: y = active_table[x] combinationally; y_valid=1 whenever rst=0.
REQ-026 REG_OUT=1: y is registered with 1-cycle latency from x; y_valid=0 in the cycle after reset, 1 thereafter.
REQ-027 REG_OUT=1, commit cycle: y registers from the old table; the new table is visible on the next edge.
REQ-028 cfg_out = shadow[2**K-1], combinational from the register, so a chained LUT receives bits 2**K cycles delayed.
REQ-029 Counter width is clog2(2**K + 1); no wrap is reachable.

Reset
REQ-030 On rst: state=RUN, active table=INIT, shadow=0, counter=0.
REQ-031 On rst, outputs take these values: cfg_ready=0, cfg_done=0, y=0 (registered), y_valid=0.
REQ-032 Reset mid-load aborts the load: no commit, no cfg_done, active table restored to INIT.
REQ-033 rst has priority over cfg_start and transfers on the same edge.

Structure
REQ-034 Package prog_lut_pkg holds the RUN/LOAD state enum, the constant K_MAX=6, and a function returning the table width 2**K.
REQ-035 One sub-module, lut_cfg_shifter (shadow register, counter, cfg_out, last-bit detect); the FSM and lookup stay in prog_lut.

Verification (K=4, REG_OUT=1 unless stated)
REQ-036 INIT=16'h8000; sweep x 0..15 at one step per 10 ns -> y=1 only for x=4'hF, 1 cycle after x is applied.
REQ-037 Load 16'h6996 MSB-first with back-to-back cfg_valid -> cfg_done at the 16th transfer; then x=4'b0111 gives y=1 and x=4'b0011 gives y=0.
REQ-038 Same load with cfg_valid low every other cycle -> identical table; cfg_done at the 16th accepted bit; y from the old table throughout.
REQ-039 Pulse cfg_start after 9 bits, then send 16 bits of 16'hFFFE -> table=16'hFFFE; x=0 gives y=0; exactly one cfg_done.
REQ-040 Assert rst after 10 bits -> table=INIT, cfg_ready=0, no cfg_done, y_valid=0 for one cycle.
REQ-041 REG_OUT=0, two chained instances, 32 bits streamed -> the second holds the first 16 bits sent, the first holds the last 16.
